// File: rtl/pipe_hazard_tracker.sv
// pipe_hazard_tracker
// -------------------
// Hazard, forwarding and stall/flush controller for the in-order KGP-RISC
// pipeline. The block keeps its own shadow copy of the post-ID stages as a
// shift register of (valid, dest, regwrite, is_load) entries. Stage 0 is EX
// and stage STAGES-1 is WB. Every ID source operand is compared against
// every stage, so RAW hazards are resolved for any number of operands and
// any pipeline depth.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   -> saturating stall and flush event counters are built
//   undefined -> no counter flops; stall_cnt and flush_cnt read as 0
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   freeze        global hold; no state advances
//   id_valid      ID holds a real instruction
//   id_src        NSRC packed source addresses, operand i at [i*REG_AW +: REG_AW]
//   id_src_used   per-operand "operand is read"
//   id_dest       ID destination register
//   id_regwrite   ID instruction writes a register
//   id_is_load    ID instruction is a load
//   branch_taken  ID resolved a taken branch/jump
//   fwd_sel       per-operand select: 0 = register file, k+1 = stage k
//   stall         load-use hazard present
//   pc_write      PC may update
//   if_id_write   IF/ID latch may update
//   if_flush      squash the instruction being fetched
//   id_bubble     the entry entering EX this edge is a bubble
//   stall_cnt     saturating count of stall cycles
//   flush_cnt     saturating count of flush cycles
//
// Handshake note: there is no valid/ready pair here. id_valid qualifies the
// ID instruction; pc_write/if_id_write are the "ready" back to fetch, and the
// ID instruction is accepted into EX on an edge where ~stall & ~freeze.
module pipe_hazard_tracker #(
  parameter int REG_AW     = 5,
  parameter int STAGES     = 3,
  parameter int NSRC       = 2,
  parameter int LOAD_STAGE = 1,
  parameter int CNT_W      = 16,
  localparam int SELW      = $clog2(STAGES + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     freeze,
  input  logic                     id_valid,
  input  logic [NSRC*REG_AW-1:0]   id_src,
  input  logic [NSRC-1:0]          id_src_used,
  input  logic [REG_AW-1:0]        id_dest,
  input  logic                     id_regwrite,
  input  logic                     id_is_load,
  input  logic                     branch_taken,
  output logic [NSRC*SELW-1:0]     fwd_sel,
  output logic                     stall,
  output logic                     pc_write,
  output logic                     if_id_write,
  output logic                     if_flush,
  output logic                     id_bubble,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt
);

  // Stage shadow: index 0 = EX (youngest), STAGES-1 = WB (oldest).
  logic [STAGES-1:0]             valid_q, valid_d;
  logic [STAGES-1:0]             rw_q,    rw_d;
  logic [STAGES-1:0]             ld_q,    ld_d;
  logic [STAGES-1:0][REG_AW-1:0] dest_q,  dest_d;

  // Per-operand match results.
  logic [NSRC-1:0][SELW-1:0] sel_c;
  logic [NSRC-1:0]           ld_hit_c;

  // Search oldest to youngest so that the youngest match overwrites any
  // older one; that gives the most recent producer priority.
  always_comb begin
    sel_c    = '0;
    ld_hit_c = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = STAGES - 1; k >= 0; k--) begin
        if (valid_q[k] && rw_q[k] && id_valid && id_src_used[i] &&
            (dest_q[k] == id_src[i*REG_AW +: REG_AW]) &&
            (dest_q[k] != '0)) begin
          sel_c[i]    = SELW'(k + 1);
          // Load data is not available yet in stages before LOAD_STAGE.
          ld_hit_c[i] = ld_q[k] && (k < LOAD_STAGE);
        end
      end
    end
  end

  // Control outputs. Stall wins over a taken branch: while stalled the
  // branch operands are not yet valid, so its decision cannot be trusted.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      fwd_sel[i*SELW +: SELW] = sel_c[i];
    end
    stall       = |ld_hit_c;
    pc_write    = ~stall & ~freeze;
    if_id_write = ~stall & ~freeze;
    if_flush    = branch_taken & ~stall & ~freeze;
    id_bubble   = stall | ~id_valid;
  end

  // Stage shift; a stalled ID instruction enters EX as a bubble.
  always_comb begin
    valid_d = valid_q;
    rw_d    = rw_q;
    ld_d    = ld_q;
    dest_d  = dest_q;
    if (!freeze) begin
      valid_d = {valid_q[STAGES-2:0], id_valid & ~stall};
      rw_d    = {rw_q[STAGES-2:0],    id_regwrite};
      ld_d    = {ld_q[STAGES-2:0],    id_is_load};
      dest_d  = {dest_q[STAGES-2:0],  id_dest};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      rw_q    <= '0;
      ld_q    <= '0;
      dest_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rw_q    <= rw_d;
      ld_q    <= ld_d;
      dest_q  <= dest_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating increments; the counters stick at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !freeze && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (if_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// Directed testbench for pipe_hazard_tracker (default parameters, plus a
// second instance with CNT_W = 2 for counter saturation). Counter
// expectations follow HAZARD_PERF_CNT_EN: the hand-computed count when the
// counters are built, 0 otherwise.
module tb_pipe_hazard_tracker;

  localparam int REG_AW = 5;
  localparam int NSRC   = 2;
  localparam int SELW   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                   freeze;
  logic                   id_valid;
  logic [NSRC*REG_AW-1:0] id_src;
  logic [NSRC-1:0]        id_src_used;
  logic [REG_AW-1:0]      id_dest;
  logic                   id_regwrite;
  logic                   id_is_load;
  logic                   branch_taken;

  logic [NSRC*SELW-1:0]   fwd_sel;
  logic                   stall, pc_write, if_id_write, if_flush, id_bubble;
  logic [15:0]            stall_cnt, flush_cnt;

  logic [NSRC*SELW-1:0]   fwd_sel2;
  logic                   stall2, pc_write2, if_id_write2, if_flush2, id_bubble2;
  logic [1:0]             stall_cnt2, flush_cnt2;

  pipe_hazard_tracker dut (
    .clk(clk), .reset(reset), .freeze(freeze), .id_valid(id_valid),
    .id_src(id_src), .id_src_used(id_src_used), .id_dest(id_dest),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load),
    .branch_taken(branch_taken), .fwd_sel(fwd_sel), .stall(stall),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_flush(if_flush),
    .id_bubble(id_bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_tracker #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .freeze(freeze), .id_valid(id_valid),
    .id_src(id_src), .id_src_used(id_src_used), .id_dest(id_dest),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load),
    .branch_taken(branch_taken), .fwd_sel(fwd_sel2), .stall(stall2),
    .pc_write(pc_write2), .if_id_write(if_id_write2), .if_flush(if_flush2),
    .id_bubble(id_bubble2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cexp(input int n);
`ifdef HAZARD_PERF_CNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] used, input logic [4:0] dest,
                       input logic rw, input logic ld, input logic br);
    id_valid     = v;
    id_src       = {s1, s0};
    id_src_used  = used;
    id_dest      = dest;
    id_regwrite  = rw;
    id_is_load   = ld;
    branch_taken = br;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    tick(); tick(); tick();
  endtask

  initial begin
    // ---------- reset state ----------
    reset  = 1'b0;
    freeze = 1'b0;
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1);
    check("rst_fwd", fwd_sel, 0);
    check("rst_stall", stall, 0);
    check("rst_pc_write", pc_write, 1);
    check("rst_if_id_write", if_id_write, 1);
    check("rst_if_flush", if_flush, 1);
    check("rst_bubble_valid", id_bubble, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    idle();
    check("rst_bubble_invalid", id_bubble, 1);
    reset = 1'b1;
    tick();

    // ---------- back-to-back ALU dependency ----------
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd3, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    check("alu_fwd_ex", fwd_sel, 4'b0001);
    check("alu_stall", stall, 0);
    tick();
    check("alu_fwd_mem", fwd_sel, 4'b0010);
    tick();
    check("alu_fwd_wb", fwd_sel, 4'b0011);
    tick();
    check("alu_fwd_rf", fwd_sel, 4'b0000);

    // ---------- youngest producer wins, both operands ----------
    drain();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    tick();  // same writer again: r7 now in stages 0 and 1
    drive(1'b1, 5'd7, 5'd7, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
    check("youngest_both_ops", fwd_sel, 4'b0101);

    // ---------- load-use ----------
    drain();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd5, 2'b10, 5'd0, 1'b0, 1'b0, 1'b0);
    check("lu_stall", stall, 1);
    check("lu_pc_write", pc_write, 0);
    check("lu_if_id_write", if_id_write, 0);
    check("lu_bubble", id_bubble, 1);
    tick();
    check("lu_stall_done", stall, 0);
    check("lu_pc_write_done", pc_write, 1);
    check("lu_fwd_mem", fwd_sel, 4'b1000);
    check("lu_stall_cnt", stall_cnt, cexp(1));
    check("lu_flush_cnt", flush_cnt, cexp(0));

    // ---------- r0 and unused operands ----------
    drain();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    check("r0_no_fwd", fwd_sel, 0);
    drain();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd4, 5'd4, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    check("unused_no_fwd", fwd_sel, 0);
    drive(1'b1, 5'd4, 5'd4, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    check("used_op0_fwd", fwd_sel, 4'b0001);
    drive(1'b0, 5'd4, 5'd4, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
    check("invalid_id_no_fwd", fwd_sel, 0);

    // ---------- branch versus stall ----------
    drain();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd6, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b1);
    check("br_stall", stall, 1);
    check("br_no_flush", if_flush, 0);
    tick();
    check("br_stall_done", stall, 0);
    check("br_flush", if_flush, 1);
    check("br_fwd", fwd_sel, 4'b0010);
    tick();
    check("br_flush_cnt", flush_cnt, cexp(1));
    check("br_stall_cnt", stall_cnt, cexp(2));

    // ---------- freeze during load-use ----------
    drain();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b1, 1'b0);
    tick();
    freeze = 1'b1;
    drive(1'b1, 5'd0, 5'd9, 2'b10, 5'd0, 1'b0, 1'b0, 1'b1);
    check("frz_stall", stall, 1);
    check("frz_pc_write", pc_write, 0);
    check("frz_if_id_write", if_id_write, 0);
    check("frz_if_flush", if_flush, 0);
    for (int c = 0; c < 4; c++) tick();
    check("frz_stall_held", stall, 1);
    check("frz_fwd_held", fwd_sel, 4'b0100);
    check("frz_stall_cnt", stall_cnt, cexp(2));
    check("frz_flush_cnt", flush_cnt, cexp(1));
    freeze = 1'b0;
    drive(1'b1, 5'd0, 5'd9, 2'b10, 5'd0, 1'b0, 1'b0, 1'b0);
    check("frz_rel_stall", stall, 1);
    tick();
    check("frz_rel_done", stall, 0);
    check("frz_rel_fwd", fwd_sel, 4'b1000);
    check("frz_rel_stall_cnt", stall_cnt, cexp(3));

    // ---------- reset mid-stall ----------
    drain();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd10, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd10, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    check("mid_stall_before", stall, 1);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_stall", stall, 0);
    check("mid_rst_pc_write", pc_write, 1);
    check("mid_rst_fwd", fwd_sel, 0);
    check("mid_rst_stall_cnt", stall_cnt, 0);
    #1 reset = 1'b1;

    // ---------- saturation: 5 load-use stalls ----------
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd11, 1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b1, 5'd11, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      tick();
    end
    check("sat_cnt16", stall_cnt, cexp(5));
    check("sat_cnt2", stall_cnt2, cexp(3));
    check("sat_flush2", flush_cnt2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #50000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
